// File: rtl/bkram_pkg.sv
// Shared types and defaults for the battery-backed cartridge RAM save/load sequencer.
package bkram_pkg;

   typedef enum logic [1:0] {IDLE, REQ, XFER} bk_state_t;

   typedef enum logic [1:0] {NONE, AUTOLOAD, LOAD, SAVE} bk_trig_t;

   localparam int BK_ACK_TIMEOUT_DEF = 1 << 20;
   localparam int BK_SECTORS_DEF     = 64;

endpackage

// File: rtl/bk_sector_xfer.sv
// Per-sector REQ/XFER handshake with the HPS: steps the sector number, re-requests
// after each ack falls and aborts when the HPS fails to acknowledge in time.
module bk_sector_xfer
   import bkram_pkg::*;
#(
   parameter int SECTORS     = BK_SECTORS_DEF,
   parameter int ACK_TIMEOUT = BK_ACK_TIMEOUT_DEF
) (
   input  logic        i_clk,
   input  logic        i_rst_n,
   input  logic        i_start,
   input  logic        i_load,
   input  logic        i_ack,
   output logic [31:0] o_lba,
   output logic        o_rd,
   output logic        o_wr,
   output logic        o_done,
   output logic        o_err
);

   localparam int LBA_W = (SECTORS > 1) ? $clog2(SECTORS) : 1;
   localparam int CNT_W = $clog2(ACK_TIMEOUT) + 1;
   localparam logic [LBA_W-1:0] LAST_LBA = LBA_W'(SECTORS - 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ACK_TIMEOUT - 1);

   bk_state_t        r_state;
   logic [LBA_W-1:0] r_lba;
   logic [CNT_W-1:0] r_cnt;
   logic             r_load;
   logic             r_ack_prev;
   logic             r_rd;
   logic             r_wr;
   logic             w_ack_rise;
   logic             w_ack_fall;

   assign w_ack_rise = i_ack & ~r_ack_prev;
   assign w_ack_fall = ~i_ack & r_ack_prev;

   // A late ack that coincides with the last timeout cycle still counts as an ack.
   assign o_done = (r_state == XFER) & w_ack_fall & (r_lba == LAST_LBA);
   assign o_err  = (r_state == REQ) & ~w_ack_rise & (r_cnt == CNT_LAST);
   assign o_lba  = 32'(r_lba);
   assign o_rd   = r_rd;
   assign o_wr   = r_wr;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state    <= IDLE;
         r_lba      <= '0;
         r_cnt      <= '0;
         r_load     <= 1'b0;
         r_ack_prev <= 1'b0;
         r_rd       <= 1'b0;
         r_wr       <= 1'b0;
      end else begin
         r_ack_prev <= i_ack;
         case (r_state)
            IDLE: begin
               if (i_start) begin
                  r_state <= REQ;
                  r_lba   <= '0;
                  r_cnt   <= '0;
                  r_load  <= i_load;
                  r_rd    <= i_load;
                  r_wr    <= ~i_load;
               end
            end
            REQ: begin
               if (w_ack_rise) begin
                  r_state <= XFER;
                  r_rd    <= 1'b0;
                  r_wr    <= 1'b0;
                  r_cnt   <= '0;
               end else if (r_cnt == CNT_LAST) begin
                  r_state <= IDLE;
                  r_rd    <= 1'b0;
                  r_wr    <= 1'b0;
                  r_cnt   <= '0;
               end else begin
                  r_cnt <= r_cnt + CNT_W'(1);
               end
            end
            XFER: begin
               if (w_ack_fall) begin
                  if (r_lba == LAST_LBA) begin
                     r_state <= IDLE;
                  end else begin
                     r_state <= REQ;
                     r_lba   <= r_lba + LBA_W'(1);
                     r_rd    <= r_load;
                     r_wr    <= ~r_load;
                  end
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

endmodule

// File: rtl/bkram_sequencer.sv
// nvram save-file sequencer: enable/dirty tracking, load/save trigger arbitration.
// Define BKRAM_AUTOSAVE_EN to add save-on-OSD-open and the pending term on led.
module bkram_sequencer
   import bkram_pkg::*;
#(
   parameter int SECTORS     = BK_SECTORS_DEF,
   parameter int ACK_TIMEOUT = BK_ACK_TIMEOUT_DEF
) (
   input  logic        clk_sys,
   input  logic        RESET_n,
   input  logic        cart_download,
   input  logic        img_mounted,
   input  logic        img_readonly,
   input  logic [63:0] img_size,
   input  logic        load_req,
   input  logic        save_req,
   input  logic        autosave,
   input  logic        osd_status,
   input  logic        nvram_we,
   input  logic        sd_ack,
   output logic [31:0] sd_lba,
   output logic        sd_rd,
   output logic        sd_wr,
   output logic        bk_ena,
   output logic        bk_busy,
   output logic        bk_loading,
   output logic        bk_pending,
   output logic        bk_err,
   output logic        led
);

   logic     r_dl_prev;
   logic     r_load_prev;
   logic     r_save_prev;
   logic     r_as_prev;
   logic     w_load_lvl;
   logic     w_save_lvl;
   logic     w_as_lvl;
   logic     w_start;
   logic     w_start_load;
   logic     w_done;
   logic     w_err;
   bk_trig_t w_trig;

   assign w_load_lvl = load_req & bk_ena;
   assign w_save_lvl = save_req & bk_ena;

`ifdef BKRAM_AUTOSAVE_EN
   assign w_as_lvl = autosave & bk_pending & osd_status & bk_ena;
   assign led      = bk_busy | (autosave & bk_pending);
`else
   logic w_unused_autosave;
   assign w_unused_autosave = autosave;
   assign w_as_lvl = 1'b0;
   assign led      = bk_busy;
`endif

   // Edge registers track every cycle, so edges seen while busy are simply lost.
   always_comb begin
      w_trig = NONE;
      if (~cart_download & r_dl_prev & (|img_size) & bk_ena)
         w_trig = AUTOLOAD;
      else if (w_load_lvl & ~r_load_prev)
         w_trig = LOAD;
      else if ((w_save_lvl & ~r_save_prev) | (w_as_lvl & ~r_as_prev))
         w_trig = SAVE;
   end

   assign w_start      = ~bk_busy & (w_trig != NONE);
   assign w_start_load = (w_trig == AUTOLOAD) | (w_trig == LOAD);

   always_ff @(posedge clk_sys or negedge RESET_n) begin
      if (!RESET_n) begin
         r_dl_prev   <= 1'b0;
         r_load_prev <= 1'b0;
         r_save_prev <= 1'b0;
         r_as_prev   <= 1'b0;
         bk_ena      <= 1'b0;
         bk_pending  <= 1'b0;
         bk_busy     <= 1'b0;
         bk_loading  <= 1'b0;
         bk_err      <= 1'b0;
      end else begin
         r_dl_prev   <= cart_download;
         r_load_prev <= w_load_lvl;
         r_save_prev <= w_save_lvl;
         r_as_prev   <= w_as_lvl;

         if (cart_download & img_mounted & ~img_readonly)
            bk_ena <= 1'b1;
         else if (cart_download & ~r_dl_prev)
            bk_ena <= 1'b0;

         if (bk_ena & ~osd_status & nvram_we)
            bk_pending <= 1'b1;
         else if (bk_busy)
            bk_pending <= 1'b0;

         if (w_start) begin
            bk_busy    <= 1'b1;
            bk_loading <= w_start_load;
            bk_err     <= 1'b0;
         end else if (w_done | w_err) begin
            bk_busy    <= 1'b0;
            bk_loading <= 1'b0;
            if (w_err)
               bk_err <= 1'b1;
         end
      end
   end

   bk_sector_xfer #(
      .SECTORS     (SECTORS),
      .ACK_TIMEOUT (ACK_TIMEOUT)
   ) u_xfer (
      .i_clk   (clk_sys),
      .i_rst_n (RESET_n),
      .i_start (w_start),
      .i_load  (w_start_load),
      .i_ack   (sd_ack),
      .o_lba   (sd_lba),
      .o_rd    (sd_rd),
      .o_wr    (sd_wr),
      .o_done  (w_done),
      .o_err   (w_err)
   );

endmodule

// File: tb/tb_bkram_sequencer.sv
// Scoreboard bench for bkram_sequencer: expected sector requests are queued by the
// stimulus, popped by a monitor; a randomized HPS model answers the handshake.
`timescale 1ns/1ps
module tb_bkram_sequencer;

   localparam int SECT = 64;
   localparam int TMO  = 100;

   logic        clk_sys = 1'b0;
   logic        RESET_n;
   logic        cart_download, img_mounted, img_readonly;
   logic [63:0] img_size;
   logic        load_req, save_req, autosave, osd_status, nvram_we;
   logic        sd_ack, ack_hps, ack_man;
   logic [31:0] sd_lba;
   logic        sd_rd, sd_wr, bk_ena, bk_busy, bk_loading, bk_pending, bk_err, led;

   always #5 clk_sys = ~clk_sys;
   assign sd_ack = ack_hps | ack_man;

   bkram_sequencer #(.SECTORS(SECT), .ACK_TIMEOUT(TMO)) dut (
      .clk_sys(clk_sys), .RESET_n(RESET_n), .cart_download(cart_download),
      .img_mounted(img_mounted), .img_readonly(img_readonly), .img_size(img_size),
      .load_req(load_req), .save_req(save_req), .autosave(autosave),
      .osd_status(osd_status), .nvram_we(nvram_we), .sd_ack(sd_ack),
      .sd_lba(sd_lba), .sd_rd(sd_rd), .sd_wr(sd_wr), .bk_ena(bk_ena),
      .bk_busy(bk_busy), .bk_loading(bk_loading), .bk_pending(bk_pending),
      .bk_err(bk_err), .led(led)
   );

   typedef struct {
      bit          rd;
      int unsigned lba;
   } req_t;

   req_t exp_q[$];
   int   n_chk  = 0;
   int   n_pass = 0;
   bit   hps_en = 1'b1;
   int   hps_fixed = 0;

   function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endfunction

   // A transfer of n sectors is a request per sector, lba 0..n-1, all in one direction.
   task automatic push_xfer(bit rd, int n);
      req_t r;
      for (int i = 0; i < n; i++) begin
         r.rd  = rd;
         r.lba = i;
         exp_q.push_back(r);
      end
   endtask

   task automatic tick(int n);
      repeat (n) @(negedge clk_sys);
   endtask

   task automatic wait_idle(string name, int budget);
      int n;
      n = 0;
      @(negedge clk_sys);
      while (bk_busy && n < budget) begin
         @(negedge clk_sys);
         n++;
      end
      check({name, "_done"}, bk_busy, 0);
   endtask

   // HPS model: acknowledge each request after a latency, release after a hold.
   initial begin
      int lat;
      ack_hps = 1'b0;
      forever begin
         @(negedge clk_sys);
         if (hps_en && (sd_rd || sd_wr)) begin
            lat = (hps_fixed != 0) ? hps_fixed : int'($urandom_range(1, 12));
            repeat (lat) @(negedge clk_sys);
            ack_hps = 1'b1;
            for (int i = 0; i < 50 && (sd_rd || sd_wr); i++) @(negedge clk_sys);
            repeat ($urandom_range(1, 4)) @(negedge clk_sys);
            ack_hps = 1'b0;
         end
      end
   end

   // Monitor: every new request must match the head of the expected queue.
   initial begin
      bit   prev;
      req_t r;
      prev = 1'b0;
      forever begin
         @(negedge clk_sys);
         if ((sd_rd || sd_wr) && !prev) begin
            if (exp_q.size() == 0) begin
               check("unexpected_request", {sd_rd, sd_wr, sd_lba}, 0);
            end else begin
               r = exp_q.pop_front();
               check("sector_req", {sd_rd, sd_wr, bk_loading, bk_busy, sd_lba},
                     {r.rd, ~r.rd, r.rd, 1'b1, r.lba});
            end
         end
         prev = sd_rd || sd_wr;
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got no completion, required finish before time limit");
      $fatal(1);
   end

   initial begin
      int kind;
      bit dirty;
      int n;
      RESET_n = 1'b0; cart_download = 1'b0; img_mounted = 1'b0; img_readonly = 1'b0;
      img_size = 64'd0; load_req = 1'b0; save_req = 1'b0; autosave = 1'b0;
      osd_status = 1'b0; nvram_we = 1'b0; ack_man = 1'b0;
      tick(3);
      check("reset_outputs", {sd_lba, sd_rd, sd_wr, bk_ena, bk_busy, bk_loading,
                              bk_pending, bk_err, led}, 0);
      RESET_n = 1'b1;
      tick(2);

      // Auto-load after a writable mount during download, fixed 10-cycle ack latency.
      hps_fixed = 10;
      cart_download = 1'b1; tick(2);
      img_mounted = 1'b1; img_readonly = 1'b0; img_size = 64'd32768; tick(1);
      img_mounted = 1'b0; tick(2);
      check("ena_after_mount", bk_ena, 1);
      push_xfer(1'b1, SECT);
      cart_download = 1'b0; tick(1);
      check("autoload_start", {bk_busy, bk_loading, sd_rd, sd_wr}, 4'b1110);
      wait_idle("autoload", 3000);
      check("autoload_loading_low", bk_loading, 0);
      check("autoload_count", exp_q.size(), 0);
      hps_fixed = 0;

      // Read-only mount: enable drops, manual requests are ignored.
      cart_download = 1'b1; tick(1);
      img_mounted = 1'b1; img_readonly = 1'b1; tick(1);
      img_mounted = 1'b0; tick(2);
      check("ena_readonly", bk_ena, 0);
      cart_download = 1'b0; tick(3);
      load_req = 1'b1; tick(1); load_req = 1'b0; tick(2);
      save_req = 1'b1; tick(1); save_req = 1'b0; tick(10);
      check("readonly_no_xfer", {bk_busy, sd_rd, sd_wr}, 0);

      // Writable remount with zero size: enabled, but no auto-load.
      cart_download = 1'b1; tick(1);
      img_mounted = 1'b1; img_readonly = 1'b0; img_size = 64'd0; tick(1);
      img_mounted = 1'b0; cart_download = 1'b0; tick(3);
      check("ena_remount", {bk_ena, bk_busy}, 2'b10);

      // Random manual transfers; load wins over simultaneous save; extra save mid-transfer.
      for (int it = 0; it < 5; it++) begin
         kind  = int'($urandom_range(0, 2));
         dirty = 1'($urandom_range(0, 1));
         if (dirty) begin
            nvram_we = 1'b1; tick(1); nvram_we = 1'b0; tick(1);
            check("pending_set", bk_pending, 1);
         end
         push_xfer(kind != 1, SECT);
         load_req = (kind != 1); save_req = (kind != 0); tick(1);
         load_req = 1'b0; save_req = 1'b0;
         check("manual_start", {bk_busy, bk_loading, sd_rd, sd_wr},
               {1'b1, kind != 1, kind != 1, kind == 1});
         tick(int'($urandom_range(20, 150)));
         save_req = 1'b1; tick(1); save_req = 1'b0;
         wait_idle("manual", 3000);
         tick(5);
         check("no_second_xfer", bk_busy, 0);
         check("pending_cleared", bk_pending, 0);
         check("manual_count", exp_q.size(), 0);
      end

      // Dirty flag and autosave on OSD open.
      autosave = 1'b1;
      nvram_we = 1'b1; tick(1); nvram_we = 1'b0; tick(1);
      check("pending_before_osd", bk_pending, 1);
`ifdef BKRAM_AUTOSAVE_EN
      check("led_pending", led, 1);
      push_xfer(1'b0, SECT);
      osd_status = 1'b1; tick(2);
      wait_idle("autosave", 3000);
      check("autosave_pending", bk_pending, 0);
`else
      check("led_pending", led, 0);
      osd_status = 1'b1; tick(50);
      check("no_autosave", {bk_busy, bk_pending}, 2'b01);
`endif
      check("autosave_count", exp_q.size(), 0);
      osd_status = 1'b0; autosave = 1'b0; tick(3);

      // Ack timeout, then a fresh save clears the error.
      hps_en = 1'b0; tick(1);
      push_xfer(1'b0, 1);
      save_req = 1'b1; tick(1); save_req = 1'b0;
      n = 0;
      while (bk_busy && n < 1000) begin
         tick(1);
         n++;
      end
      check("timeout_cycles", n, TMO);
      check("timeout_state", {sd_rd, sd_wr, bk_busy, bk_loading, bk_err}, 5'b00001);
      hps_en = 1'b1;
      push_xfer(1'b0, SECT);
      save_req = 1'b1; tick(1); save_req = 1'b0;
      check("err_cleared", {bk_err, bk_busy}, 2'b01);
      wait_idle("after_timeout", 3000);
      check("after_timeout_count", exp_q.size(), 0);
      tick(3);

      // Reset in the middle of sector 17, then stray acks.
      push_xfer(1'b1, 18);
      load_req = 1'b1; tick(1); load_req = 1'b0;
      n = 0;
      while (!(sd_rd && sd_lba == 32'd17) && n < 2000) begin
         tick(1);
         n++;
      end
      check("reached_sector17", {sd_rd, sd_lba}, {1'b1, 32'd17});
      hps_en = 1'b0;
      #2 RESET_n = 1'b0;
      #1;
      check("reset_async", {sd_lba, sd_rd, sd_wr, bk_ena, bk_busy, bk_loading,
                            bk_pending, bk_err, led}, 0);
      tick(3);
      RESET_n = 1'b1;
      tick(30);
      for (int i = 0; i < 4; i++) begin
         ack_man = 1'b1; tick(3);
         ack_man = 1'b0; tick(3);
      end
      check("post_reset_idle", {sd_rd, sd_wr, bk_busy, bk_ena}, 0);
      check("reset_count", exp_q.size(), 0);

      tick(5);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
